// File: rtl/s298_bist_pkg.sv
// Shared types and constants for the s298 BIST response analyser.
package s298_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_WARM    = 3'd2,
    ST_COMPACT = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam int RESP_W = 6;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'h0000;

  // Position of each s298 primary output inside RESP.
  localparam int IDX_G66  = 0;
  localparam int IDX_G67  = 1;
  localparam int IDX_G117 = 2;
  localparam int IDX_G118 = 3;
  localparam int IDX_G132 = 4;
  localparam int IDX_G133 = 5;

endpackage

// File: rtl/s298_misr.sv
// W-bit multiple-input signature register: shift left, fold MSB through the
// tap mask, XOR the zero-extended response into the low bits.
module s298_misr
  import s298_bist_pkg::*;
#(
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [W-1:0]      seed,
  input  logic [RESP_W-1:0] data,
  input  logic [W-1:0]      taps,
  output logic [W-1:0]      sig
);

  logic [W-1:0] next_sig;

  always_comb begin
    next_sig = {sig[W-2:0], 1'b0}
             ^ (sig[W-1] ? taps : {W{1'b0}})
             ^ {{(W-RESP_W){1'b0}}, data};
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      sig <= seed;
    end else if (en) begin
      sig <= next_sig;
    end
  end

endmodule

// File: rtl/s298_misr_analyzer.sv
// BIST output response analyser for s298: skips a warm-up window, compacts
// NUM_PATTERNS responses into a MISR and compares against GOLDEN.
module s298_misr_analyzer
  import s298_bist_pkg::*;
#(
  parameter int          W            = 16,
  parameter logic [W-1:0] POLY        = W'(DEFAULT_POLY),
  parameter logic [W-1:0] SEED        = W'(DEFAULT_SEED),
  parameter int          WARMUP       = 14,
  parameter int          NUM_PATTERNS = 255,
  parameter int          CW           = $clog2(NUM_PATTERNS + WARMUP + 1)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic              RESP_VALID,
  input  logic [RESP_W-1:0] RESP,
  input  logic [W-1:0]      GOLDEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [W-1:0]      SIGNATURE,
  output logic [CW-1:0]     COUNT,
  output state_e            STATE
);

  // Count value held on the edge that accepts the last warm-up / last
  // compacted response; that edge also advances the state.
  localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [CW-1:0] COMP_LAST = CW'(WARMUP + NUM_PATTERNS - 1);

  // RESP_VALID has no ready: a response is consumed on every edge where
  // RESP_VALID=1 while in WARM or COMPACT, and dropped in any other state.
  logic              start_ok;
  logic              misr_en;
  logic              accept;
  logic [RESP_W-1:0] resp_ord;

  assign resp_ord = {RESP[IDX_G133], RESP[IDX_G132], RESP[IDX_G118],
                     RESP[IDX_G117], RESP[IDX_G67],  RESP[IDX_G66]};

  assign start_ok = START && ((STATE == ST_IDLE) || (STATE == ST_DONE));
  assign accept   = RESP_VALID && ((STATE == ST_WARM) || (STATE == ST_COMPACT));
  assign misr_en  = RESP_VALID && (STATE == ST_COMPACT);

  s298_misr #(
    .W (W)
  ) u_misr (
    .clk  (CK),
    .rst  (RST),
    .load (start_ok),
    .en   (misr_en),
    .seed (SEED),
    .data (resp_ord),
    .taps (POLY),
    .sig  (SIGNATURE)
  );

  always_ff @(posedge CK) begin
    if (RST) begin
      STATE <= ST_IDLE;
      COUNT <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      PASS  <= 1'b0;
    end else begin
      if (accept) begin
        COUNT <= COUNT + 1'b1;
      end
      case (STATE)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            STATE <= ST_SEED;
            COUNT <= '0;
            PASS  <= 1'b0;
            BUSY  <= 1'b1;
            DONE  <= 1'b0;
          end
        end
        ST_SEED: begin
          STATE <= (WARMUP > 0) ? ST_WARM : ST_COMPACT;
        end
        ST_WARM: begin
          if (RESP_VALID && (COUNT == WARM_LAST)) begin
            STATE <= ST_COMPACT;
          end
        end
        ST_COMPACT: begin
          if (RESP_VALID && (COUNT == COMP_LAST)) begin
            STATE <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          PASS  <= (SIGNATURE == GOLDEN);
          STATE <= ST_DONE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        default: begin
          STATE <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          PASS  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s298_misr_analyzer.sv
// Bench for s298_misr_analyzer: four parameterisations, directed scenarios
// plus a randomised default-parameter session against a bit-level model.
module tb_s298_misr_analyzer;
  import s298_bist_pkg::*;

  // ---------------- clock / reset ----------------
  logic CK  = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic        exp_pass_q[$];

  // ---------------- instance a: WARMUP=0, NUM_PATTERNS=2 ----------------
  logic        a_start = 0, a_rv = 0;
  logic [5:0]  a_resp = '0;
  logic [15:0] a_gold = '0;
  logic        a_busy, a_done, a_pass;
  logic [15:0] a_sig;
  logic [1:0]  a_cnt;
  state_e      a_st;
  s298_misr_analyzer #(.WARMUP(0), .NUM_PATTERNS(2), .SEED(16'h0000)) u_a (
    .CK(CK), .RST(RST), .START(a_start), .RESP_VALID(a_rv), .RESP(a_resp),
    .GOLDEN(a_gold), .BUSY(a_busy), .DONE(a_done), .PASS(a_pass),
    .SIGNATURE(a_sig), .COUNT(a_cnt), .STATE(a_st));

  // ---------------- instance b: SEED=0x8000, NUM_PATTERNS=1 ----------------
  logic        b_start = 0, b_rv = 0;
  logic [5:0]  b_resp = '0;
  logic [15:0] b_gold = '0;
  logic        b_busy, b_done, b_pass;
  logic [15:0] b_sig;
  logic [0:0]  b_cnt;
  state_e      b_st;
  s298_misr_analyzer #(.WARMUP(0), .NUM_PATTERNS(1), .SEED(16'h8000)) u_b (
    .CK(CK), .RST(RST), .START(b_start), .RESP_VALID(b_rv), .RESP(b_resp),
    .GOLDEN(b_gold), .BUSY(b_busy), .DONE(b_done), .PASS(b_pass),
    .SIGNATURE(b_sig), .COUNT(b_cnt), .STATE(b_st));

  // ---------------- instance c: WARMUP=3, NUM_PATTERNS=1 ----------------
  logic        c_start = 0, c_rv = 0;
  logic [5:0]  c_resp = '0;
  logic [15:0] c_gold = '0;
  logic        c_busy, c_done, c_pass;
  logic [15:0] c_sig;
  logic [2:0]  c_cnt;
  state_e      c_st;
  s298_misr_analyzer #(.WARMUP(3), .NUM_PATTERNS(1), .SEED(16'h0000)) u_c (
    .CK(CK), .RST(RST), .START(c_start), .RESP_VALID(c_rv), .RESP(c_resp),
    .GOLDEN(c_gold), .BUSY(c_busy), .DONE(c_done), .PASS(c_pass),
    .SIGNATURE(c_sig), .COUNT(c_cnt), .STATE(c_st));

  // ---------------- instance d: default parameters ----------------
  logic        d_start = 0, d_rv = 0;
  logic [5:0]  d_resp = '0;
  logic [15:0] d_gold = '0;
  logic        d_busy, d_done, d_pass;
  logic [15:0] d_sig;
  logic [8:0]  d_cnt;
  state_e      d_st;
  s298_misr_analyzer u_d (
    .CK(CK), .RST(RST), .START(d_start), .RESP_VALID(d_rv), .RESP(d_resp),
    .GOLDEN(d_gold), .BUSY(d_busy), .DONE(d_done), .PASS(d_pass),
    .SIGNATURE(d_sig), .COUNT(d_cnt), .STATE(d_st));

  // ---------------- model / driver tasks ----------------
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'b0, r};
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({a_sig, b_sig, c_sig, d_sig} !== {16'h0000, 16'h8000, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_sig got %h %h %h %h exp 0000 8000 0000 0000", a_sig, b_sig, c_sig, d_sig);
    end
    checks++;
    if ({a_cnt, b_cnt, c_cnt, d_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_count got %0d %0d %0d %0d exp 0", a_cnt, b_cnt, c_cnt, d_cnt);
    end
    checks++;
    if ({a_busy, a_done, a_pass, d_busy, d_done, d_pass} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b%b %b%b%b exp 000 000", a_busy, a_done, a_pass, d_busy, d_done, d_pass);
    end
    checks++;
    if (a_st !== ST_IDLE || d_st !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d %0d exp %0d", a_st, d_st, ST_IDLE);
    end
    // START on the same edge as RST must lose.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_st !== ST_IDLE || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_with_rst got state %0d busy %b exp %0d 0", a_st, a_busy, ST_IDLE);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] e;
    logic        ep;
    a_gold  = 16'h0002;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++;
    if (a_st !== ST_SEED || a_busy !== 1'b1 || a_sig !== 16'h0000) begin
      errors++;
      $display("FAIL basic_seed got state %0d busy %b sig %h exp %0d 1 0000", a_st, a_busy, a_sig, ST_SEED);
    end
    // A valid response during SEED must be dropped.
    a_rv   = 1'b1;
    a_resp = 6'h3f;
    tick();
    checks++;
    if (a_st !== ST_COMPACT || a_cnt !== 2'd0 || a_sig !== 16'h0000) begin
      errors++;
      $display("FAIL basic_seed_ignore got state %0d cnt %0d sig %h exp %0d 0 0000", a_st, a_cnt, a_sig, ST_COMPACT);
    end
    exp_q.push_back(16'h0002);
    exp_pass_q.push_back(1'b1);
    a_resp = 6'h01;
    tick();
    checks++;
    if (a_sig !== 16'h0001 || a_cnt !== 2'd1) begin
      errors++;
      $display("FAIL basic_first got sig %h cnt %0d exp 0001 1", a_sig, a_cnt);
    end
    a_resp = 6'h00;
    tick();
    checks++;
    if (a_sig !== 16'h0002 || a_cnt !== 2'd2 || a_st !== ST_CHECK || a_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_second got sig %h cnt %0d state %0d done %b exp 0002 2 %0d 0", a_sig, a_cnt, a_st, a_done, ST_CHECK);
    end
    a_rv = 1'b0;
    tick();
    e  = exp_q.pop_front();
    ep = exp_pass_q.pop_front();
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_sig !== e || a_pass !== ep || a_cnt !== 2'd2) begin
      errors++;
      $display("FAIL basic_done got done %b busy %b sig %h pass %b cnt %0d exp 1 0 %h %b 2", a_done, a_busy, a_sig, a_pass, a_cnt, e, ep);
    end
  endtask

  task automatic test_feedback();
    logic [15:0] e;
    logic        ep;
    b_gold  = 16'h1020;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    b_rv   = 1'b1;
    b_resp = 6'h00;
    exp_q.push_back(16'h1021);
    exp_pass_q.push_back(1'b0);
    tick();
    b_rv = 1'b0;
    for (int i = 0; i < 8 && !b_done; i++) tick();
    e  = exp_q.pop_front();
    ep = exp_pass_q.pop_front();
    checks++;
    if (b_done !== 1'b1 || b_sig !== e || b_pass !== ep) begin
      errors++;
      $display("FAIL feedback got done %b sig %h pass %b exp 1 %h %b", b_done, b_sig, b_pass, e, ep);
    end
  endtask

  task automatic test_warmup();
    logic [15:0] e;
    logic        ep;
    c_gold  = 16'h0005;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      c_rv   = 1'b1;
      c_resp = 6'h3f;
      tick();
      c_rv = 1'b0;
      checks++;
      if (c_sig !== 16'h0000 || c_cnt !== 3'(k + 1)) begin
        errors++;
        $display("FAIL warm_accept%0d got sig %h cnt %0d exp 0000 %0d", k, c_sig, c_cnt, k + 1);
      end
      repeat (k + 1) tick();
      checks++;
      if (c_sig !== 16'h0000 || c_cnt !== 3'(k + 1)) begin
        errors++;
        $display("FAIL warm_stall%0d got sig %h cnt %0d exp 0000 %0d", k, c_sig, c_cnt, k + 1);
      end
    end
    checks++;
    if (c_st !== ST_COMPACT) begin
      errors++;
      $display("FAIL warm_to_compact got state %0d exp %0d", c_st, ST_COMPACT);
    end
    c_rv   = 1'b1;
    c_resp = 6'h05;
    exp_q.push_back(16'h0005);
    exp_pass_q.push_back(1'b1);
    tick();
    c_rv = 1'b0;
    for (int i = 0; i < 8 && !c_done; i++) tick();
    e  = exp_q.pop_front();
    ep = exp_pass_q.pop_front();
    checks++;
    if (c_done !== 1'b1 || c_sig !== e || c_pass !== ep || c_cnt !== 3'd4) begin
      errors++;
      $display("FAIL warm_done got done %b sig %h pass %b cnt %0d exp 1 %h %b 4", c_done, c_sig, c_pass, c_cnt, e, ep);
    end
  endtask

  task automatic test_reset_mid();
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    tick();
    d_rv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d_resp = 6'($urandom_range(0, 63));
      tick();
    end
    d_rv = 1'b0;
    checks++;
    if (d_st !== ST_COMPACT || d_cnt !== 9'd16) begin
      errors++;
      $display("FAIL mid_setup got state %0d cnt %0d exp %0d 16", d_st, d_cnt, ST_COMPACT);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (d_st !== ST_IDLE || d_sig !== 16'h0000 || d_cnt !== 9'd0 || d_busy !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got state %0d sig %h cnt %0d busy %b done %b exp %0d 0000 0 0 0", d_st, d_sig, d_cnt, d_busy, d_done, ST_IDLE);
    end
  endtask

  // Full default-parameter session with random data and stalls; optionally
  // pulses START mid-COMPACT, and chooses whether GOLDEN matches.
  task automatic test_regression(input bit match, input bit poke_start);
    logic [15:0] model;
    logic [15:0] e;
    logic        ep;
    int          n;
    bit          poked;
    model = 16'h0000;
    n     = 0;
    poked = 1'b0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    checks++;
    if (d_st !== ST_SEED || d_pass !== 1'b0 || d_sig !== 16'h0000 || d_cnt !== 9'd0) begin
      errors++;
      $display("FAIL regr_seed got state %0d pass %b sig %h cnt %0d exp %0d 0 0000 0", d_st, d_pass, d_sig, d_cnt, ST_SEED);
    end
    tick();
    for (int cyc = 0; cyc < 2000 && n < 269; cyc++) begin
      if (poke_start && !poked && n == 20) begin
        poked   = 1'b1;
        d_rv    = 1'b0;
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        checks++;
        if (d_sig !== model || d_cnt !== 9'(n) || d_st !== ST_COMPACT) begin
          errors++;
          $display("FAIL start_busy got sig %h cnt %0d state %0d exp %h %0d %0d", d_sig, d_cnt, d_st, model, n, ST_COMPACT);
        end
      end else begin
        d_rv   = ($urandom_range(0, 3) != 0);
        d_resp = 6'($urandom_range(0, 63));
        if (d_rv) begin
          if (n >= 14) model = misr_step(model, d_resp);
          n++;
        end
        tick();
        checks++;
        if (d_sig !== model || d_cnt !== 9'(n)) begin
          errors++;
          $display("FAIL regr_step%0d got sig %h cnt %0d exp %h %0d", n, d_sig, d_cnt, model, n);
        end
      end
    end
    d_rv   = 1'b0;
    d_gold = match ? model : (model ^ 16'h0001);
    exp_q.push_back(model);
    exp_pass_q.push_back(match);
    for (int i = 0; i < 8 && !d_done; i++) tick();
    e  = exp_q.pop_front();
    ep = exp_pass_q.pop_front();
    checks++;
    if (d_done !== 1'b1 || d_sig !== e || d_pass !== ep || d_cnt !== 9'd269) begin
      errors++;
      $display("FAIL regr_done got done %b sig %h pass %b cnt %0d exp 1 %h %b 269", d_done, d_sig, d_pass, d_cnt, e, ep);
    end
    repeat (3) tick();
    checks++;
    if (d_done !== 1'b1 || d_sig !== e || d_pass !== ep) begin
      errors++;
      $display("FAIL regr_hold got done %b sig %h pass %b exp 1 %h %b", d_done, d_sig, d_pass, e, ep);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_feedback();
    test_warmup();
    test_reset_mid();
    test_regression(1'b1, 1'b1);
    test_regression(1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
